fft8_bitrev_reorder: RTL
========================

Name: fft8_bitrev_reorder

Overview:
- Downstream of the 8-point radix-2 butterfly stages. Collects one frame of 8 complex butterfly results, which arrive in bit-reversed order.
- Re-emits the frame in natural order X[0]..X[7] over a valid/ready stream.
- Ping-pong double buffer (2 banks x 8 complex words): one frame can fill while the previous frame drains.
- Optional arithmetic right shift on output removes fixed-point growth (data is signed, 256 = 1.0).

Parameters:
- DATA_W, 32, width of each signed real/imag sample.
- OUT_SHIFT, 0, arithmetic right shift applied to out_real/out_imag (0..DATA_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sync_clr  input  1  synchronous clear; drops all buffered/partial frames.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept an input sample.
- in_real  input  DATA_W  signed real part, bit-reversed frame order.
- in_imag  input  DATA_W  signed imag part.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts output.
- out_real  output  DATA_W  signed real part, natural order, shifted.
- out_imag  output  DATA_W  signed imag part, natural order, shifted.
- out_index  output  3  natural-order bin index of current output.
- out_last  output  1  high with bin 7 of a frame.

Behaviour:
- State: wr_bank, rd_bank (1b); wr_cnt, rd_cnt (3b); full[1:0]; mem[2][8] of {real, imag}.
- Reset (rst_n=0, async): all of the above = 0. Outputs: in_ready=1, out_valid=0, out_real=out_imag=0, out_index=0, out_last=0. Memory contents are not cleared.
- sync_clr=1 at a clock edge: same state clear as reset, synchronous. It takes priority over any simultaneous accept or drain.
- Write:
  - in_ready = !full[wr_bank] (combinational from registers).
  - Accept when in_valid && in_ready: mem[wr_bank][bitrev(wr_cnt)] <= {in_real, in_imag}, wr_cnt++.
  - bitrev maps k[2:0] to {k[0],k[1],k[2]}; the write sequence is 0,4,2,6,1,5,3,7.
  - Accept at wr_cnt==7: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
- Read:
  - out_valid = full[rd_bank].
  - out_real/out_imag = mem[rd_bank][rd_cnt] >>> OUT_SHIFT (sign-preserving) when out_valid; 0 otherwise.
  - out_index = rd_cnt.
  - out_last = out_valid && rd_cnt==7.
- Drain: when out_valid && out_ready, rd_cnt++. At rd_cnt==7: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
- Latency: out_valid rises in the cycle after the edge that accepts the 8th input of a frame.
- Throughput: 1 sample/cycle sustained in and out, with no bubbles between frames.
- Both banks full: in_ready=0; input holds off until a bank fully drains. in_ready returns 1 the cycle after out_last is accepted.
- Same-edge set of full on one bank and clear on the other: both take effect; there is no conflict because the banks differ.
- out_ready low: out_* hold stable; rd_cnt frozen.
- in_valid with in_ready=0: nothing is written; the upstream must hold its data.
- Reset or sync_clr mid-frame: partial frame is discarded; next accepted sample is frame position 0 into bank 0.
- Arithmetic: no saturation. Shift is arithmetic (sign-extending), truncating toward minus infinity.

Test Plan:
- Reset/idle: rst_n low then high with no input -> in_ready=1, out_valid=0, out_real=out_imag=0, out_index=0, out_last=0.
- Single frame, out_ready=1: input real=0..7 on consecutive cycles, imag=-real -> out_real sequence 0,4,2,6,1,5,3,7; out_imag negated; out_index 0..7; out_last only on index 7; first out_valid one cycle after the 8th accept.
- Backpressure: 3 frames back-to-back with out_ready=0 -> in_ready drops after 16 accepts. Raise out_ready -> frame 1 then frame 2 drain in order; in_ready=1 the cycle after frame 1's out_last; frame 3 completes.
- Streaming: continuous in_valid=1, out_ready=1 for 4 frames -> no idle cycles on out_valid after the first frame; order correct per frame.
- Shift/sign: OUT_SHIFT=2, input real=-256, imag=1023 at position 0 -> out_real=-64, out_imag=255 at index 0.
- Mid-frame clear: 5 samples accepted, then sync_clr pulse (repeat with rst_n pulse), then a full new frame -> only the new frame is emitted, in correct natural order, with no stale data.

Source files
------------

// File: rtl/fft8_bitrev_reorder.sv
// Collects an 8-point FFT frame arriving in bit-reversed order and re-emits it in
// natural order, using a ping-pong pair of 8-word banks so fill and drain overlap.
module fft8_bitrev_reorder #(
    parameter int DATA_W    = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [2:0]        out_index,
    output logic              out_last
);

    logic                wr_bank;
    logic                rd_bank;
    logic [2:0]          wr_cnt;
    logic [2:0]          rd_cnt;
    logic [1:0]          full;
    logic [2*DATA_W-1:0] mem [2][8];

    logic                in_acc;
    logic                out_acc;
    logic [2:0]          wr_addr;
    logic [2*DATA_W-1:0] rd_word;
    logic signed [DATA_W-1:0] rd_real;
    logic signed [DATA_W-1:0] rd_imag;
    logic signed [DATA_W-1:0] sh_real;
    logic signed [DATA_W-1:0] sh_imag;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and the sender holds data until the transfer.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    // Arrival slot k belongs to natural bin bitrev(k).
    assign wr_addr = {wr_cnt[0], wr_cnt[1], wr_cnt[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= 3'd0;
            rd_cnt  <= 3'd0;
            full    <= 2'b00;
        end else if (sync_clr) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= 3'd0;
            rd_cnt  <= 3'd0;
            full    <= 2'b00;
        end else begin
            if (in_acc) begin
                wr_cnt <= wr_cnt + 3'd1;
                if (wr_cnt == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            // A bank being filled is never the bank being drained, so both updates
            // to full can land on the same edge.
            if (out_acc) begin
                rd_cnt <= rd_cnt + 3'd1;
                if (rd_cnt == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc && !sync_clr && rst_n) begin
            mem[wr_bank][wr_addr] <= {in_real, in_imag};
        end
    end

    assign rd_word = mem[rd_bank][rd_cnt];
    assign rd_real = rd_word[2*DATA_W-1:DATA_W];
    assign rd_imag = rd_word[DATA_W-1:0];
    assign sh_real = rd_real >>> OUT_SHIFT;
    assign sh_imag = rd_imag >>> OUT_SHIFT;

    assign out_real  = out_valid ? sh_real : '0;
    assign out_imag  = out_valid ? sh_imag : '0;
    assign out_index = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == 3'd7);

endmodule
